linear_backward: RTL
====================

Name: linear_backward

Overview:
Backward-pass counterpart of the forward linear layer (Y = X·W + B). Given the layer input X, weights W and upstream gradient G = dL/dY, it computes:
- grad_in = G·Wᵀ
- grad_weights = Xᵀ·G
- grad_biases = column sums of G

It uses a single sequential 32-bit MAC driven by an FSM with nested counters. It sits in the training datapath after the next layer's backward stage and uses the same enable/done handshake as the forward layer.

Parameters:
- INPUT_SIZE, 4, features per sample (I)
- COUNT, 1, samples per batch (C)
- OUTPUT_SIZE, 4, outputs per sample (O)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  start request, level, sampled in IDLE
- busy  out  1  high while computing
- done  out  1  results valid
- data_in  in  [31:0] x [COUNT][INPUT_SIZE]  forward input X
- weights  in  [31:0] x [INPUT_SIZE][OUTPUT_SIZE]  W
- grad_out  in  [31:0] x [COUNT][OUTPUT_SIZE]  G
- grad_in  out  [31:0] x [COUNT][INPUT_SIZE]  dL/dX
- grad_weights  out  [31:0] x [INPUT_SIZE][OUTPUT_SIZE]  dL/dW
- grad_biases  out  [31:0] x [OUTPUT_SIZE]  dL/dB

Behaviour:
- Interface: one clock, clk; reset synchronous, active-high, rst.
- Reset: on the rst edge, FSM goes to IDLE; busy=0, done=0; all grad_* elements=0; counters and accumulator=0. Reset mid-run aborts the run; no partial results are retained.
- Arithmetic:
  - 32-bit two's complement.
  - Each product is the low 32 bits of the signed product.
  - Accumulation wraps modulo 2^32; no saturation.
- FSM states: IDLE, GRAD_IN, GRAD_W, GRAD_B, DONE.
- IDLE:
  - On an edge with enable=1: capture data_in, weights and grad_out into internal registers, then go to GRAD_IN with busy=1.
  - Inputs may change after the capture edge.
- GRAD_IN:
  - Loop order: n over C, i over I, k over O, k innermost.
  - One MAC per cycle: acc += G[n][k]*W[i][k].
  - On k=O-1, write grad_in[n][i] = acc + product, then clear acc.
  - Duration C·I·O cycles.
- GRAD_W:
  - Loop order: i, o, n (n innermost).
  - acc += X[n][i]*G[n][o]; on n=C-1, write grad_weights[i][o].
  - Duration I·O·C cycles.
- GRAD_B:
  - Loop order: o, n (n innermost).
  - acc += G[n][o]; on n=C-1, write grad_biases[o].
  - Duration O·C cycles.
- Completion:
  - On the final write edge, go to DONE; done=1, busy=0 are registered on that same edge.
  - Latency L = 2·C·I·O + C·O edges after the capture edge.
- DONE:
  - done holds 1 while enable=1.
  - On an edge with enable=0: go to IDLE, done=0.
  - A new run requires enable to drop first; no back-to-back restart from DONE.
- enable deasserted mid-run: ignored; the run completes, done pulses for at least 1 cycle, then the FSM returns to IDLE.
- Result stability: grad_* outputs hold their last values until overwritten by the next run. They are valid only while done=1; during a run they update element by element.
- Degenerate size: C=I=O=1 is legal, giving L=3.

Optional Feature:
- Macro: LINEAR_BACKWARD_BIAS_EN.
- Defined: GRAD_B phase present; grad_biases computed; L = 2·C·I·O + C·O.
- Undefined: GRAD_B skipped, with GRAD_W going directly to DONE; grad_biases tied to 0; L = 2·C·I·O.

Test Plan:
1. Basic run, C=1, I=2, O=2, X=[1,2], W=[[1,2],[3,4]], G=[5,6], enable pulse held high -> grad_in=[17,39]; grad_weights=[[5,6],[10,12]]; grad_biases=[5,6]; done rises exactly 10 edges after capture (8 without the macro); busy high throughout.
2. Signed values, X=[-1,3], G=[-2,4], same W -> grad_in=[6,10]; grad_weights=[[2,-4],[-6,12]]; grad_biases=[-2,4].
3. Wrap-around: C=I=O=1, X=W=G=0x00010000 -> grad_in=0, grad_weights=0, grad_biases=0x00010000, done after 3 edges.
4. Reset mid-run: assert rst 4 edges into test 1 -> next edge busy=0, done=0, all outputs 0, FSM IDLE; a re-run with enable gives the test 1 results.
5. Handshake: hold enable high through DONE -> done stays 1 with no restart; drop enable -> done=0 next edge; change inputs during a run -> results reflect the captured values.
6. Batch: C=2, I=1, O=1, X=[[2],[3]], W=[[7]], G=[[1],[4]] -> grad_in=[7,28]; grad_weights=[[14]]; grad_biases=[5]; L=6.

Source files
------------

// File: rtl/linear_backward.sv
// ---------------------------------------------------------------------------
// linear_backward
//   Backward pass of a fully connected layer (forward pass Y = X*W + B).
//   Given the layer input X, the weights W and the upstream gradient
//   G = dL/dY, it computes:
//     grad_in      = G * W^T          [COUNT][INPUT_SIZE]
//     grad_weights = X^T * G          [INPUT_SIZE][OUTPUT_SIZE]
//     grad_biases  = column sums of G [OUTPUT_SIZE]
//   The work is done by one sequential 32-bit multiply-accumulate unit,
//   stepped by an FSM with nested loop counters. Products keep the low
//   32 bits of the signed product and accumulation wraps modulo 2^32.
//
//   Optional build macro: LINEAR_BACKWARD_BIAS_EN
//     defined   : GRAD_B phase runs and grad_biases is computed
//     undefined : GRAD_W goes straight to DONE and grad_biases reads 0
//
// Ports
//   clk          : clock
//   rst          : synchronous active-high reset (aborts any run)
//   enable       : start request (level); sampled in IDLE, released in DONE
//   busy         : high while computing
//   done         : results valid; held while enable stays high
//   data_in      : forward input X        [COUNT][INPUT_SIZE]
//   weights      : weights W              [INPUT_SIZE][OUTPUT_SIZE]
//   grad_out     : upstream gradient G    [COUNT][OUTPUT_SIZE]
//   grad_in      : dL/dX                  [COUNT][INPUT_SIZE]
//   grad_weights : dL/dW                  [INPUT_SIZE][OUTPUT_SIZE]
//   grad_biases  : dL/dB                  [OUTPUT_SIZE]
// ---------------------------------------------------------------------------
module linear_backward #(
  parameter int INPUT_SIZE  = 4,
  parameter int COUNT       = 1,
  parameter int OUTPUT_SIZE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        busy,
  output logic        done,
  input  logic [31:0] data_in      [COUNT][INPUT_SIZE],
  input  logic [31:0] weights      [INPUT_SIZE][OUTPUT_SIZE],
  input  logic [31:0] grad_out     [COUNT][OUTPUT_SIZE],
  output logic [31:0] grad_in      [COUNT][INPUT_SIZE],
  output logic [31:0] grad_weights [INPUT_SIZE][OUTPUT_SIZE],
  output logic [31:0] grad_biases  [OUTPUT_SIZE]
);

  localparam int NW = (COUNT > 1)       ? $clog2(COUNT)       : 1;
  localparam int IW = (INPUT_SIZE > 1)  ? $clog2(INPUT_SIZE)  : 1;
  localparam int KW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRAD_IN = 3'd1;
  localparam logic [2:0] S_GRAD_W  = 3'd2;
  localparam logic [2:0] S_GRAD_B  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [NW-1:0] n_q, n_d;   // sample index
  logic [IW-1:0] i_q, i_d;   // input-feature index
  logic [KW-1:0] k_q, k_d;   // output index
  logic [31:0]   acc_q, acc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Operands captured at start so the caller may change inputs mid-run.
  logic [31:0] x_q  [COUNT][INPUT_SIZE];
  logic [31:0] w_q  [INPUT_SIZE][OUTPUT_SIZE];
  logic [31:0] g_q  [COUNT][OUTPUT_SIZE];
  logic [31:0] gi_q [COUNT][INPUT_SIZE];
  logic [31:0] gw_q [INPUT_SIZE][OUTPUT_SIZE];

  logic [31:0] op_a_s, op_b_s, prod_s, sum_s;
  logic        n_last_s, i_last_s, k_last_s;
  logic        cap_s, wr_gi_s, wr_gw_s, wr_gb_s;

  assign n_last_s = (n_q == NW'(COUNT - 1));
  assign i_last_s = (i_q == IW'(INPUT_SIZE - 1));
  assign k_last_s = (k_q == KW'(OUTPUT_SIZE - 1));
  assign cap_s    = (state_q == S_IDLE) && enable;

  // Low 32 bits of a product are identical for signed and unsigned operands.
  assign prod_s = op_a_s * op_b_s;
  assign sum_s  = acc_q + prod_s;

  // Operand select for the shared MAC; kept apart from the next-state logic
  // so no block both feeds and consumes sum_s.
  always_comb begin
    op_a_s = 32'd0;
    op_b_s = 32'd0;
    case (state_q)
      S_GRAD_IN: begin
        op_a_s = g_q[n_q][k_q];
        op_b_s = w_q[i_q][k_q];
      end
      S_GRAD_W: begin
        op_a_s = x_q[n_q][i_q];
        op_b_s = g_q[n_q][k_q];
      end
`ifdef LINEAR_BACKWARD_BIAS_EN
      S_GRAD_B: begin
        // Bias gradient is a plain sum: multiply by one reuses the MAC.
        op_a_s = g_q[n_q][k_q];
        op_b_s = 32'd1;
      end
`endif
      default: begin
        op_a_s = 32'd0;
        op_b_s = 32'd0;
      end
    endcase
  end

  // FSM, loop counters and accumulator next state.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    k_d     = k_q;
    acc_d   = acc_q;
    wr_gi_s = 1'b0;
    wr_gw_s = 1'b0;
    wr_gb_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_GRAD_IN;
          n_d     = NW'(0);
          i_d     = IW'(0);
          k_d     = KW'(0);
          acc_d   = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      // n outer, i middle, k innermost.
      S_GRAD_IN: begin
        if (k_last_s) begin
          wr_gi_s = 1'b1;
          acc_d   = 32'd0;
          k_d     = KW'(0);
          if (i_last_s) begin
            i_d = IW'(0);
            if (n_last_s) begin
              n_d     = NW'(0);
              state_d = S_GRAD_W;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          acc_d = sum_s;
          k_d   = k_q + KW'(1);
        end
      end
      // i outer, k (output) middle, n innermost.
      S_GRAD_W: begin
        if (n_last_s) begin
          wr_gw_s = 1'b1;
          acc_d   = 32'd0;
          n_d     = NW'(0);
          if (k_last_s) begin
            k_d = KW'(0);
            if (i_last_s) begin
              i_d = IW'(0);
`ifdef LINEAR_BACKWARD_BIAS_EN
              state_d = S_GRAD_B;
`else
              state_d = S_DONE;
`endif
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end else begin
          acc_d = sum_s;
          n_d   = n_q + NW'(1);
        end
      end
`ifdef LINEAR_BACKWARD_BIAS_EN
      // k (output) outer, n innermost.
      S_GRAD_B: begin
        if (n_last_s) begin
          wr_gb_s = 1'b1;
          acc_d   = 32'd0;
          n_d     = NW'(0);
          if (k_last_s) begin
            k_d     = KW'(0);
            state_d = S_DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end else begin
          acc_d = sum_s;
          n_d   = n_q + NW'(1);
        end
      end
`endif
      S_DONE: begin
        // Release needs enable low; no restart straight from DONE.
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_GRAD_IN) || (state_d == S_GRAD_W) ||
             (state_d == S_GRAD_B);
    done_d = (state_d == S_DONE);
  end

  // Control state, operand capture and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= NW'(0);
      i_q     <= IW'(0);
      k_q     <= KW'(0);
      acc_q   <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int n = 0; n < COUNT; n++) begin
        for (int i = 0; i < INPUT_SIZE; i++) begin
          x_q[n][i]  <= 32'd0;
          gi_q[n][i] <= 32'd0;
        end
        for (int k = 0; k < OUTPUT_SIZE; k++) begin
          g_q[n][k] <= 32'd0;
        end
      end
      for (int i = 0; i < INPUT_SIZE; i++) begin
        for (int k = 0; k < OUTPUT_SIZE; k++) begin
          w_q[i][k]  <= 32'd0;
          gw_q[i][k] <= 32'd0;
        end
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (cap_s) begin
        x_q <= data_in;
        w_q <= weights;
        g_q <= grad_out;
      end
      if (wr_gi_s) begin
        gi_q[n_q][i_q] <= sum_s;
      end
      if (wr_gw_s) begin
        gw_q[i_q][k_q] <= sum_s;
      end
    end
  end

`ifdef LINEAR_BACKWARD_BIAS_EN
  logic [31:0] gb_q [OUTPUT_SIZE];

  // Bias-gradient result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < OUTPUT_SIZE; k++) begin
        gb_q[k] <= 32'd0;
      end
    end else if (wr_gb_s) begin
      gb_q[k_q] <= sum_s;
    end
  end

  assign grad_biases = gb_q;
`else
  // Bias gradient disabled: outputs tied to zero.
  always_comb begin
    for (int k = 0; k < OUTPUT_SIZE; k++) begin
      grad_biases[k] = 32'd0;
    end
  end

  logic unused_wr_gb_s;
  assign unused_wr_gb_s = wr_gb_s;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign grad_in      = gi_q;
  assign grad_weights = gw_q;

endmodule
